// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: format codes,
// select-field layout and the datapath-width legality test.
package imm_pkg;

  // Immediate format codes carried in SELECT[2:0]
  localparam logic [2:0] IMM_U     = 3'b000;
  localparam logic [2:0] IMM_J     = 3'b001;
  localparam logic [2:0] IMM_I     = 3'b010;
  localparam logic [2:0] IMM_B     = 3'b011;
  localparam logic [2:0] IMM_S     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_ILL   = 3'b111;

  // SELECT bit that forces zero-extension instead of sign-extension
  localparam int UNSIGNED_BIT = 3;

  // Only RV32 and RV64 datapaths are supported
  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: picks the instruction fields for the
// requested format, extends them and flags the reserved format code.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic [31:0]     INST,
  input  logic [3:0]      SELECT,
  output logic [XLEN-1:0] IMM,
  output logic            ERR
);

  // Everything is built at 64 bits and truncated, so one decoder serves both widths
  logic [63:0] w_imm64;
  logic        w_sign;

  // Field selection and extension for each format
  always_comb begin
    w_imm64 = '0;
    ERR     = 1'b0;
    w_sign  = INST[31] & ~SELECT[UNSIGNED_BIT];
    case (SELECT[2:0])
      // U ignores the unsigned flag: upper bits always follow INST[31]
      IMM_U:     w_imm64 = {{32{INST[31]}}, INST[31:12], 12'b0};
      IMM_J:     w_imm64 = {{43{w_sign}}, INST[31], INST[19:12], INST[20], INST[30:21], 1'b0};
      IMM_I:     w_imm64 = {{52{w_sign}}, INST[31:20]};
      IMM_B:     w_imm64 = {{51{w_sign}}, INST[31], INST[7], INST[30:25], INST[11:8], 1'b0};
      IMM_S:     w_imm64 = {{52{w_sign}}, INST[31:25], INST[11:7]};
      IMM_SHAMT: w_imm64[SHAMT_W-1:0] = INST[20 +: SHAMT_W];
      IMM_ZIMM:  w_imm64 = {59'b0, INST[19:15]};
      default:   ERR = 1'b1;
    endcase
  end

  assign IMM = w_imm64[XLEN-1:0];

  // Opcode bits and (on RV32) the upper half of the scratch value carry no immediate data
  generate
    if (XLEN < 64) begin : g_narrow
      logic w_unused_bits;
      assign w_unused_bits = ^{INST[6:0], w_imm64[63:XLEN]};
    end else begin : g_wide
      logic w_unused_bits;
      assign w_unused_bits = ^INST[6:0];
    end
  endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer at the ID-stage
// boundary. Immediate and PC-relative target are computed on the input side
// so both storage slots hold finished results.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INST,
  input  logic [XLEN-1:0] IN_PC,
  input  logic [3:0]      SELECT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [XLEN-1:0] OUT_TARGET,
  output logic [31:0]     OUT_INST,
  output logic [XLEN-1:0] OUT_PC,
  output logic            OUT_ERR
);

  generate
    if (!xlen_legal(XLEN)) begin : g_xlen_illegal
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            err;
  } entry_t;

  entry_t r_os;        // output slot, drives OUT_*
  entry_t r_ss;        // skid slot, catches the accept that races a stall
  logic   r_os_valid;
  logic   r_ss_valid;
  logic   r_in_ready;

  logic [XLEN-1:0] w_imm;
  logic            w_err;
  entry_t          w_in_entry;
  logic            w_accept;
  logic            w_drain;
  logic            w_ss_valid_next;

  imm_extract #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_extract (
    .INST   (IN_INST),
    .SELECT (SELECT),
    .IMM    (w_imm),
    .ERR    (w_err)
  );

  assign w_in_entry.imm    = w_imm;
  assign w_in_entry.target = IN_PC + w_imm;
  assign w_in_entry.pc     = IN_PC;
  assign w_in_entry.inst   = IN_INST;
  assign w_in_entry.err    = w_err;

  assign w_accept = IN_VALID & r_in_ready;
  // Output slot can load this edge when it is empty or its entry is leaving
  assign w_drain  = ~r_os_valid | OUT_READY;
  // Skid slot stays busy only if it refills while draining or catches a stalled accept
  assign w_ss_valid_next = w_drain ? (r_ss_valid & w_accept) : (r_ss_valid | w_accept);

  // Slot occupancy and the registered ready; FLUSH drops held entries and any same-cycle accept
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_os_valid <= 1'b0;
      r_ss_valid <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (FLUSH) begin
      r_os_valid <= 1'b0;
      r_ss_valid <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_drain) begin
        r_os_valid <= r_ss_valid | w_accept;
      end
      r_ss_valid <= w_ss_valid_next;
      r_in_ready <= ~w_ss_valid_next;
    end
  end

  // Slot payloads; the skid entry always moves ahead of a new accept to keep order
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_os <= '0;
      r_ss <= '0;
    end else if (!FLUSH) begin
      if (w_drain) begin
        if (r_ss_valid) begin
          r_os <= r_ss;
        end else if (w_accept) begin
          r_os <= w_in_entry;
        end
        if (r_ss_valid && w_accept) begin
          r_ss <= w_in_entry;
        end
      end else if (w_accept) begin
        r_ss <= w_in_entry;
      end
    end
  end

  assign IN_READY   = r_in_ready;
  assign OUT_VALID  = r_os_valid;
  assign OUT_IMM    = r_os.imm;
  assign OUT_TARGET = r_os.target;
  assign OUT_INST   = r_os.inst;
  assign OUT_PC     = r_os.pc;
  assign OUT_ERR    = r_os.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed vectors, backpressure, flush,
// reset and randomized traffic against a behavioural immediate model.
module tb_imm_gen_pipe;

  localparam int XLEN = 32;

  logic            CLK;
  logic            RESET;
  logic            FLUSH;
  logic            IN_VALID;
  logic            IN_READY;
  logic [31:0]     IN_INST;
  logic [XLEN-1:0] IN_PC;
  logic [3:0]      SELECT;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] OUT_IMM;
  logic [XLEN-1:0] OUT_TARGET;
  logic [31:0]     OUT_INST;
  logic [XLEN-1:0] OUT_PC;
  logic            OUT_ERR;

  // Second instance exercises the RV64 datapath
  logic        FLUSH_64;
  logic        IN_VALID_64;
  logic        IN_READY_64;
  logic [31:0] IN_INST_64;
  logic [63:0] IN_PC_64;
  logic [3:0]  SELECT_64;
  logic        OUT_VALID_64;
  logic        OUT_READY_64;
  logic [63:0] OUT_IMM_64;
  logic [63:0] OUT_TARGET_64;
  logic [31:0] OUT_INST_64;
  logic [63:0] OUT_PC_64;
  logic        OUT_ERR_64;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb[$];
  bit   rnd_on = 0;

  imm_gen_pipe #(.XLEN(XLEN)) u_dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST), .IN_PC(IN_PC),
    .SELECT(SELECT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_IMM(OUT_IMM), .OUT_TARGET(OUT_TARGET), .OUT_INST(OUT_INST),
    .OUT_PC(OUT_PC), .OUT_ERR(OUT_ERR)
  );

  imm_gen_pipe #(.XLEN(64)) u_dut64 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH_64),
    .IN_VALID(IN_VALID_64), .IN_READY(IN_READY_64), .IN_INST(IN_INST_64), .IN_PC(IN_PC_64),
    .SELECT(SELECT_64), .OUT_VALID(OUT_VALID_64), .OUT_READY(OUT_READY_64),
    .OUT_IMM(OUT_IMM_64), .OUT_TARGET(OUT_TARGET_64), .OUT_INST(OUT_INST_64),
    .OUT_PC(OUT_PC_64), .OUT_ERR(OUT_ERR_64)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Two's-complement interpretation of a w-bit field unless the unsigned flag is set
  function automatic longint sx(input longint f, input int w, input bit u);
    if (!u && f >= (longint'(1) << (w - 1))) return f - (longint'(1) << w);
    return f;
  endfunction

  // Reference immediate/target computed arithmetically from the format rules
  function automatic exp_t ref_model(input logic [31:0] inst, input logic [3:0] sel,
                                     input logic [63:0] pc, input int xlen);
    exp_t   e;
    longint v;
    longint mask;
    bit     u;
    int     shw;
    u     = sel[3];
    shw   = (xlen == 64) ? 6 : 5;
    v     = 0;
    e.err = 1'b0;
    case (sel[2:0])
      3'd0: v = longint'($signed(inst & 32'hFFFF_F000));
      3'd1: v = sx(longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21, u);
      3'd2: v = sx(longint'(inst[31:20]), 12, u);
      3'd3: v = sx(longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13, u);
      3'd4: v = sx(longint'({inst[31:25], inst[11:7]}), 12, u);
      3'd5: v = (longint'(inst) >> 20) % (longint'(1) << shw);
      3'd6: v = (longint'(inst) >> 15) % 32;
      default: begin v = 0; e.err = 1'b1; end
    endcase
    mask   = (xlen == 64) ? -64'sd1 : 64'h0000_0000_FFFF_FFFF;
    e.imm  = v & mask;
    e.tgt  = (longint'(pc) + v) & mask;
    e.pc   = pc & mask;
    e.inst = inst;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops on every output handshake, pushes on every input accept, checks stall stability
  logic        prev_stall = 1'b0;
  logic [63:0] prev_imm, prev_tgt, prev_pc;
  logic [31:0] prev_inst;
  logic        prev_err;
  always @(negedge CLK) begin
    if (RESET || FLUSH) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", 64'(OUT_VALID), 64'd1);
        chk("stall_hold_data", {OUT_IMM, OUT_TARGET} ^ {OUT_PC, OUT_INST, 31'b0, OUT_ERR},
            {prev_imm[31:0], prev_tgt[31:0]} ^ {prev_pc[31:0], prev_inst, 31'b0, prev_err});
      end
      if (OUT_VALID && OUT_READY) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got inst 0x%08h with no entry expected", OUT_INST);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (64'(OUT_IMM) !== e.imm || 64'(OUT_TARGET) !== e.tgt || OUT_INST !== e.inst ||
              64'(OUT_PC) !== e.pc || OUT_ERR !== e.err) begin
            failures++;
            $display("FAIL sb_entry: got inst=%08h imm=%0h tgt=%0h pc=%0h err=%0b expected inst=%08h imm=%0h tgt=%0h pc=%0h err=%0b",
                     OUT_INST, OUT_IMM, OUT_TARGET, OUT_PC, OUT_ERR,
                     e.inst, e.imm, e.tgt, e.pc, e.err);
          end
        end
      end
      if (IN_VALID && IN_READY) sb.push_back(ref_model(IN_INST, SELECT, 64'(IN_PC), XLEN));
      prev_stall = OUT_VALID && !OUT_READY;
      prev_imm   = 64'(OUT_IMM);
      prev_tgt   = 64'(OUT_TARGET);
      prev_pc    = 64'(OUT_PC);
      prev_inst  = OUT_INST;
      prev_err   = OUT_ERR;
    end
  end

  // Random downstream readiness while the random phase runs
  always @(posedge CLK) begin
    if (rnd_on) begin
      #1;
      OUT_READY = ($urandom_range(0, 3) != 0);
    end
  end

  // All tasks start and end one time unit after a rising edge
  task automatic send_one(input logic [31:0] inst, input logic [3:0] sel, input logic [XLEN-1:0] pc);
    bit done;
    done     = 1'b0;
    IN_VALID = 1'b1;
    IN_INST  = inst;
    SELECT   = sel;
    IN_PC    = pc;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge CLK);
      done = IN_READY;
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout: got no accept for inst 0x%08h required accept within 50 cycles", inst);
    end
  endtask

  task automatic direct(input string name, input logic [31:0] inst, input logic [3:0] sel,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] e_imm,
                        input logic [XLEN-1:0] e_tgt, input logic e_err);
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    IN_INST   = inst;
    SELECT    = sel;
    IN_PC     = pc;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk({name, "_valid"}, 64'(OUT_VALID), 64'd1);
    chk({name, "_imm"},   64'(OUT_IMM),   64'(e_imm));
    chk({name, "_tgt"},   64'(OUT_TARGET), 64'(e_tgt));
    chk({name, "_err"},   64'(OUT_ERR),   64'(e_err));
    @(posedge CLK);
    #1;
  endtask

  task automatic direct64(input string name, input logic [31:0] inst, input logic [3:0] sel,
                          input logic [63:0] pc, input logic [63:0] e_imm, input logic [63:0] e_tgt,
                          input logic e_err);
    OUT_READY_64 = 1'b1;
    IN_VALID_64  = 1'b1;
    IN_INST_64   = inst;
    SELECT_64    = sel;
    IN_PC_64     = pc;
    @(posedge CLK);
    #1;
    IN_VALID_64 = 1'b0;
    @(negedge CLK);
    chk({name, "_valid"}, 64'(OUT_VALID_64), 64'd1);
    chk({name, "_imm"},   OUT_IMM_64,        e_imm);
    chk({name, "_tgt"},   OUT_TARGET_64,     e_tgt);
    chk({name, "_err"},   64'(OUT_ERR_64),   64'(e_err));
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    OUT_READY = 1'b1;
    for (int w = 0; w < 20 && (sb.size() != 0 || OUT_VALID); w++) begin
      @(posedge CLK);
      #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN_INST = '0; IN_PC = '0; SELECT = '0;
    OUT_READY = 1'b0;
    FLUSH_64 = 1'b0; IN_VALID_64 = 1'b0; IN_INST_64 = '0; IN_PC_64 = '0; SELECT_64 = '0;
    OUT_READY_64 = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_in_ready",  64'(IN_READY),  64'd1);
    chk("rst_out_err",   64'(OUT_ERR),   64'd0);
    chk("rst_out_data",  64'(OUT_IMM | OUT_TARGET | OUT_PC | OUT_INST), 64'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Directed format vectors
    direct("b_neg",   32'hFE000EE3, 4'b0011, 32'h100,  32'hFFFF_FFFC, 32'h0000_00FC, 1'b0);
    direct("i_sext",  32'hFFF00093, 4'b0010, 32'h0,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    direct("i_zext",  32'hFFF00093, 4'b1010, 32'h0,    32'h0000_0FFF, 32'h0000_0FFF, 1'b0);
    direct("u_type",  32'h123450B7, 4'b0000, 32'h10,   32'h1234_5000, 32'h1234_5010, 1'b0);
    direct("illegal", 32'h123450B7, 4'b0111, 32'h200,  32'h0,         32'h200,       1'b1);
    direct("j_fwd",   32'h0080006F, 4'b0001, 32'h1000, 32'h8,         32'h1008,      1'b0);
    direct("shamt32", 32'h03F01013, 4'b0101, 32'h4,    32'h1F,        32'h23,        1'b0);
    direct("zimm",    32'h000F8073, 4'b0110, 32'h0,    32'h1F,        32'h1F,        1'b0);
    direct("s_sext",  32'hFE112E23, 4'b0100, 32'h8,    32'hFFFF_FFFC, 32'h4,         1'b0);
    direct("s_zext",  32'hFE112E23, 4'b1100, 32'h8,    32'h0000_0FFC, 32'h1004,      1'b0);
    direct("wrap",    32'h800000B7, 4'b0000, 32'h9000_0000, 32'h8000_0000, 32'h1000_0000, 1'b0);

    // RV64 datapath
    direct64("u64",     32'h800000B7, 4'b0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    direct64("shamt64", 32'h03F01013, 4'b0101, 64'h1_0000_0000, 64'h3F, 64'h1_0000_003F, 1'b0);
    direct64("ill64",   32'h03F01013, 4'b1111, 64'h40, 64'h0, 64'h40, 1'b1);
    for (int k = 0; k < 16; k++) begin
      logic [31:0] ri;
      logic [3:0]  rs;
      logic [63:0] rp;
      ri = $urandom;
      rs = 4'($urandom_range(0, 15));
      rp = {$urandom, $urandom};
      e  = ref_model(ri, rs, rp, 64);
      direct64("rand64", ri, rs, rp, e.imm, e.tgt, e.err);
    end

    // Backpressure: two accepts fill both slots, ready drops, order preserved on release
    OUT_READY = 1'b0;
    send_one(32'h00500093, 4'b0010, 32'h40);
    send_one(32'h123450B7, 4'b0000, 32'h44);
    @(negedge CLK);
    chk("bp_in_ready_low", 64'(IN_READY), 64'd0);
    chk("bp_os_first",     64'(OUT_INST), 64'h0050_0093);
    @(posedge CLK);
    #1;
    fork
      send_one(32'hFFF00093, 4'b1010, 32'h48);
      begin
        repeat (2) begin
          @(negedge CLK);
          chk("bp_in_ready_held", 64'(IN_READY), 64'd0);
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
      end
    join
    send_one(32'h0080006F, 4'b0001, 32'h4C);
    drain();

    // Flush with both slots full and a pending input
    OUT_READY = 1'b0;
    send_one(32'h00A00093, 4'b0010, 32'h80);
    send_one(32'h00B00093, 4'b0010, 32'h84);
    IN_VALID = 1'b1; IN_INST = 32'hDEAD00B7; SELECT = 4'b0000; IN_PC = 32'h88;
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    chk("flush_out_valid", 64'(OUT_VALID), 64'd0);
    chk("flush_in_ready",  64'(IN_READY),  64'd1);
    @(posedge CLK);
    #1;
    // Flush while the skid slot is free, so the same-cycle input would otherwise be taken
    send_one(32'h00C00093, 4'b0010, 32'h90);
    IN_VALID = 1'b1; IN_INST = 32'hBEEF00B7; SELECT = 4'b0000; IN_PC = 32'h94;
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    chk("flush2_out_valid", 64'(OUT_VALID), 64'd0);
    @(posedge CLK);
    #1;
    direct("post_flush", 32'h00100093, 4'b0010, 32'h100, 32'h1, 32'h101, 1'b0);
    drain();

    // Reset in the middle of a stall
    OUT_READY = 1'b0;
    send_one(32'h00D00093, 4'b0010, 32'hA0);
    send_one(32'h00E00093, 4'b0010, 32'hA4);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("midrst_in_ready",  64'(IN_READY),  64'd1);
    chk("midrst_out_data",  64'(OUT_IMM | OUT_TARGET | OUT_PC | OUT_INST | 32'(OUT_ERR)), 64'd0);
    @(posedge CLK);
    #1;
    direct("post_rst", 32'h0080006F, 4'b0001, 32'h200, 32'h8, 32'h208, 1'b0);
    drain();

    // Randomized traffic under random downstream stalls
    rnd_on = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send_one($urandom, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge CLK);
        #1;
      end
    end
    rnd_on = 1'b0;
    @(posedge CLK);
    #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
